// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read arbiter: burst codes, AR control field
// widths and the arbiter state encoding.
package axi_pkg;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    localparam int LenW   = 4;
    localparam int SizeW  = 2;
    localparam int BurstW = 2;
    localparam int LockW  = 2;
    localparam int CacheW = 4;
    localparam int ProtW  = 3;
    localparam int ArCtrlW = LenW + SizeW + BurstW + LockW + CacheW + ProtW;

    // Full registered AR payload: address plus all control fields.
    function automatic int ar_payload_w(input int bus_width);
        return bus_width + ArCtrlW;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axi_outstanding_ctr.sv
// Per-master count of accepted-but-incomplete bursts, with a limit flag that
// gates eligibility and an underflow flag for completions nobody asked for.
module axi_outstanding_ctr #(
    parameter int MaxOutstanding = 4,
    parameter int CntBits        = 3
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic inc,
    input  logic dec,
    output logic at_limit,
    output logic underflow
);

    logic [CntBits-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value regardless of statement order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   cnt <= cnt + CntBits'(1);
                2'b01:   if (cnt != '0) cnt <= cnt - CntBits'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign at_limit  = (cnt >= CntBits'(MaxOutstanding));
    assign underflow = dec && (cnt == '0);

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master round-robin arbiter for the AXI read path: registers the winning
// AR request toward the slave and routes R beats back by the RID tag MSB.
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int BusWidth       = 32,
    parameter int IdBits         = 1,
    parameter int MaxOutstanding = 4,
    parameter int CntBits        = 3
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic [IdBits-1:0]   m0_arid,
    input  logic [BusWidth-1:0] m0_araddr,
    input  logic [LenW-1:0]     m0_arlen,
    input  logic [SizeW-1:0]    m0_arsize,
    input  logic [BurstW-1:0]   m0_arburst,
    input  logic [LockW-1:0]    m0_arlock,
    input  logic [CacheW-1:0]   m0_arcache,
    input  logic [ProtW-1:0]    m0_arprot,
    input  logic                m0_arvalid,
    output logic                m0_arready,

    input  logic [IdBits-1:0]   m1_arid,
    input  logic [BusWidth-1:0] m1_araddr,
    input  logic [LenW-1:0]     m1_arlen,
    input  logic [SizeW-1:0]    m1_arsize,
    input  logic [BurstW-1:0]   m1_arburst,
    input  logic [LockW-1:0]    m1_arlock,
    input  logic [CacheW-1:0]   m1_arcache,
    input  logic [ProtW-1:0]    m1_arprot,
    input  logic                m1_arvalid,
    output logic                m1_arready,

    output logic [IdBits:0]     s_arid,
    output logic [BusWidth-1:0] s_araddr,
    output logic [LenW-1:0]     s_arlen,
    output logic [SizeW-1:0]    s_arsize,
    output logic [BurstW-1:0]   s_arburst,
    output logic [LockW-1:0]    s_arlock,
    output logic [CacheW-1:0]   s_arcache,
    output logic [ProtW-1:0]    s_arprot,
    output logic                s_arvalid,
    input  logic                s_arready,

    input  logic [IdBits:0]     s_rid,
    input  logic [BusWidth-1:0] s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic                s_rvalid,
    output logic                s_rready,

    output logic [IdBits-1:0]   m0_rid,
    output logic [BusWidth-1:0] m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    output logic                m0_rvalid,
    input  logic                m0_rready,

    output logic [IdBits-1:0]   m1_rid,
    output logic [BusWidth-1:0] m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    output logic                m1_rvalid,
    input  logic                m1_rready,

    output logic                err
);

    localparam int ArPayloadW = ar_payload_w(BusWidth);

    arb_state_e            state, state_next;
    logic                  rr_ptr;          // 0: M0 wins a tie, 1: M1 wins a tie
    logic                  grant0, grant1;
    logic                  limit0, limit1;
    logic                  under0, under1;
    logic                  elig0, elig1;
    logic                  r_sel, r_done;
    logic [ArPayloadW-1:0] ar_q;
    logic [ArPayloadW-1:0] m0_payload, m1_payload;

    assign m0_payload = {m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arlock, m0_arcache, m0_arprot};
    assign m1_payload = {m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arlock, m1_arcache, m1_arprot};
    assign {s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot} = ar_q;

    assign elig0 = m0_arvalid && !limit0;
    assign elig1 = m1_arvalid && !limit1;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 && (!elig1 || !rr_ptr)) grant0 = 1'b1;
                else if (elig1)                   grant1 = 1'b1;
                if (grant0 || grant1) state_next = SEND;
            end
            SEND: begin
                if (s_arready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign m0_arready = grant0;
    assign m1_arready = grant1;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            s_arvalid <= 1'b0;
            s_arid    <= '0;
            ar_q      <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            if (grant0) begin
                s_arid    <= {1'b0, m0_arid};
                ar_q      <= m0_payload;
                s_arvalid <= 1'b1;
                rr_ptr    <= 1'b1;
            end else if (grant1) begin
                s_arid    <= {1'b1, m1_arid};
                ar_q      <= m1_payload;
                s_arvalid <= 1'b1;
                rr_ptr    <= 1'b0;
            end else if (state == SEND && s_arready) begin
                s_arvalid <= 1'b0;
            end
            if (under0 || under1) err <= 1'b1;
        end
    end

    // R path is pure steering; the tag MSB names the owning master.
    assign r_sel     = s_rid[IdBits];
    assign s_rready  = r_sel ? m1_rready : m0_rready;
    assign r_done    = s_rvalid && s_rready && s_rlast;

    assign m0_rid    = s_rid[IdBits-1:0];
    assign m0_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m0_rvalid = s_rvalid && !r_sel;

    assign m1_rid    = s_rid[IdBits-1:0];
    assign m1_rdata  = s_rdata;
    assign m1_rresp  = s_rresp;
    assign m1_rlast  = s_rlast;
    assign m1_rvalid = s_rvalid && r_sel;

    axi_outstanding_ctr #(
        .MaxOutstanding (MaxOutstanding),
        .CntBits        (CntBits)
    ) u_ctr0 (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .inc       (grant0),
        .dec       (r_done && !r_sel),
        .at_limit  (limit0),
        .underflow (under0)
    );

    axi_outstanding_ctr #(
        .MaxOutstanding (MaxOutstanding),
        .CntBits        (CntBits)
    ) u_ctr1 (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .inc       (grant1),
        .dec       (r_done && r_sel),
        .at_limit  (limit1),
        .underflow (under1)
    );

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed and randomized bench for axi_read_arbiter, checked against a
// transaction-level model of grants, outstanding counts and the error flag.
module tb_axi_read_arbiter;
    import axi_pkg::*;

    localparam int BW  = 32;
    localparam int PW  = BW + 17;
    localparam int MAX = 4;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;

    logic [0:0]    m0_arid, m1_arid;
    logic [BW-1:0] m0_araddr, m1_araddr;
    logic [3:0]    m0_arlen, m1_arlen, m0_arcache, m1_arcache;
    logic [1:0]    m0_arsize, m1_arsize, m0_arburst, m1_arburst, m0_arlock, m1_arlock;
    logic [2:0]    m0_arprot, m1_arprot;
    logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;

    logic [1:0]    s_arid;
    logic [BW-1:0] s_araddr;
    logic [3:0]    s_arlen, s_arcache;
    logic [1:0]    s_arsize, s_arburst, s_arlock;
    logic [2:0]    s_arprot;
    logic          s_arvalid, s_arready;

    logic [1:0]    s_rid;
    logic [BW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast, s_rvalid, s_rready;

    logic [0:0]    m0_rid, m1_rid;
    logic [BW-1:0] m0_rdata, m1_rdata;
    logic [1:0]    m0_rresp, m1_rresp;
    logic          m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic          err;

    axi_read_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arlock(m0_arlock), .m0_arcache(m0_arcache), .m0_arprot(m0_arprot),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arlock(m1_arlock), .m1_arcache(m1_arcache), .m1_arprot(m1_arprot),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .err(err)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one request in flight toward the slave at most,
    // per-master outstanding burst counts, tie-break preference, sticky error.
    bit          mdl_busy;
    int          mdl_out[2];
    int          mdl_pref;
    bit          mdl_err;
    logic [1:0]  mdl_tag;
    logic [PW-1:0] mdl_pay;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] req_payload(input int n);
        if (n == 0)
            return {m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arlock, m0_arcache, m0_arprot};
        return {m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arlock, m1_arcache, m1_arprot};
    endfunction

    function automatic logic [1:0] pick_burst();
        logic [1:0] b;
        case ($urandom_range(2))
            0:       b = FIXED;
            1:       b = INCR;
            default: b = WRAP;
        endcase
        return b;
    endfunction

    task automatic rand_req(input int n);
        if (n == 0) begin
            m0_arid = 1'($urandom); m0_araddr = $urandom; m0_arlen = 4'($urandom);
            m0_arsize = 2'($urandom); m0_arburst = pick_burst(); m0_arlock = 2'($urandom);
            m0_arcache = 4'($urandom); m0_arprot = 3'($urandom);
        end else begin
            m1_arid = 1'($urandom); m1_araddr = $urandom; m1_arlen = 4'($urandom);
            m1_arsize = 2'($urandom); m1_arburst = pick_burst(); m1_arlock = 2'($urandom);
            m1_arcache = 4'($urandom); m1_arprot = 3'($urandom);
        end
    endtask

    task automatic model_reset();
        mdl_busy = 0; mdl_out[0] = 0; mdl_out[1] = 0; mdl_pref = 0; mdl_err = 0;
        mdl_tag = '0; mdl_pay = '0;
    endtask

    task automatic check_ar_side(input string tag);
        check({tag, ".s_arvalid"}, 64'(s_arvalid), 64'(mdl_busy));
        if (mdl_busy) begin
            check({tag, ".s_arid"}, 64'(s_arid), 64'(mdl_tag));
            check({tag, ".payload"}, 64'({s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot}),
                  64'(mdl_pay));
        end
        check({tag, ".err"}, 64'(err), 64'(mdl_err));
    endtask

    // One clock: entered at posedge+1 with inputs set; checks combinational
    // outputs, advances the model across the edge, then checks registered outputs.
    task automatic step(input string tag);
        bit e0, e1, sel, rdy, done;
        int g;
        #3;
        e0 = m0_arvalid && (mdl_out[0] < MAX);
        e1 = m1_arvalid && (mdl_out[1] < MAX);
        g = -1;
        if (!mdl_busy) begin
            if (e0 && e1) g = mdl_pref;
            else if (e0)  g = 0;
            else if (e1)  g = 1;
        end
        check({tag, ".m0_arready"}, 64'(m0_arready), 64'(g == 0));
        check({tag, ".m1_arready"}, 64'(m1_arready), 64'(g == 1));
        sel = s_rid[1];
        rdy = sel ? m1_rready : m0_rready;
        check({tag, ".s_rready"},  64'(s_rready),  64'(rdy));
        check({tag, ".m0_rvalid"}, 64'(m0_rvalid), 64'(s_rvalid && !sel));
        check({tag, ".m1_rvalid"}, 64'(m1_rvalid), 64'(s_rvalid && sel));
        check({tag, ".m1_rid"},    64'(m1_rid),    64'(s_rid[0]));
        check({tag, ".m0_rdata"},  64'(m0_rdata),  64'(s_rdata));
        done = s_rvalid && rdy && s_rlast;
        @(posedge ACLK);
        if (done) begin
            if (mdl_out[sel] == 0) mdl_err = 1;
            if (!(g == int'(sel))) begin
                if (mdl_out[sel] > 0) mdl_out[sel]--;
            end
        end
        if (g >= 0) begin
            if (!(done && g == int'(sel))) mdl_out[g]++;
            mdl_busy = 1;
            mdl_tag  = {g[0], (g == 0) ? m0_arid : m1_arid};
            mdl_pay  = req_payload(g);
            mdl_pref = 1 - g;
        end else if (mdl_busy && s_arready) begin
            mdl_busy = 0;
        end
        #1;
        check_ar_side(tag);
    endtask

    task automatic clear_r();
        s_rvalid = 0; s_rlast = 0; s_rid = 2'b00; m0_rready = 0; m1_rready = 0;
    endtask

    task automatic do_reset();
        ARESETn = 0;
        model_reset();
        repeat (2) @(posedge ACLK);
        #1;
        check("reset.s_arvalid", 64'(s_arvalid), 64'(0));
        check("reset.m0_arready", 64'(m0_arready), 64'(0));
        check("reset.m1_arready", 64'(m1_arready), 64'(0));
        check("reset.err", 64'(err), 64'(0));
        check("reset.s_arid", 64'(s_arid), 64'(0));
        check("reset.payload", 64'({s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot}), 64'(0));
        ARESETn = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_arvalid = 0; m1_arvalid = 0; s_arready = 0;
        rand_req(0); rand_req(1);
        s_rdata = '0; s_rresp = '0;
        clear_r();
        model_reset();

        // Reset state.
        do_reset();

        // M0 alone: accepted in one cycle, visible to the slave the next.
        m0_arid = 1'b1; m0_araddr = 32'h100; m0_arlen = 4'd3; m0_arburst = INCR;
        m0_arvalid = 1; s_arready = 1;
        step("m0_only.accept");
        check("m0_only.s_arid", 64'(s_arid), 64'(2'b01));
        check("m0_only.s_araddr", 64'(s_araddr), 64'(32'h100));
        m0_arvalid = 0;
        step("m0_only.send");
        step("m0_only.idle");

        // Both masters held valid from reset: M0, M1, M0 alternate.
        do_reset();
        m0_arvalid = 1; m1_arvalid = 1; rand_req(0); rand_req(1);
        step("both.g0");
        check("both.first_msb", 64'(s_arid[1]), 64'(0));
        step("both.s0");
        step("both.g1");
        check("both.second_msb", 64'(s_arid[1]), 64'(1));
        step("both.s1");
        step("both.g2");
        check("both.third_msb", 64'(s_arid[1]), 64'(0));
        m0_arvalid = 0; m1_arvalid = 0;
        step("both.s2");

        // Slave stalls for 5 cycles: request and payload stay put while the
        // master-side payload keeps changing.
        m0_arvalid = 1; rand_req(0);
        step("stall.accept");
        s_arready = 0;
        for (int i = 0; i < 5; i++) begin
            rand_req(0);
            step($sformatf("stall.hold%0d", i));
        end
        m0_arvalid = 0; s_arready = 1;
        step("stall.release");

        // M1 fills its outstanding budget; M0 is still served; one RLAST frees M1.
        do_reset();
        m1_arvalid = 1; s_arready = 1;
        for (int i = 0; i < 20 && mdl_out[1] < MAX; i++) begin
            rand_req(1);
            step("fill.m1");
        end
        m0_arvalid = 1;
        for (int i = 0; i < 4; i++) begin
            rand_req(0);
            step("fill.m0_served");
        end
        m0_arvalid = 0;
        s_rid = 2'b10; s_rvalid = 1; s_rlast = 1; m1_rready = 1; s_rdata = $urandom;
        step("fill.rlast_m1");
        clear_r();
        step("fill.m1_readmitted");
        check("fill.m1_tag_msb", 64'(s_arid[1]), 64'(1));
        m1_arvalid = 0;
        step("fill.send");

        // R routing to M1 with back-pressure, then completion.
        s_rid = 2'b11; s_rvalid = 1; m1_rready = 0; m0_rready = 1; s_rdata = $urandom; s_rresp = 2'b10;
        step("route.stalled");
        check("route.m1_rresp", 64'(m1_rresp), 64'(2'b10));
        m1_rready = 1; s_rlast = 1;
        step("route.complete");
        clear_r();

        // Completion for an idle master sets a sticky error.
        do_reset();
        s_rid = 2'b00; s_rvalid = 1; s_rlast = 1; m0_rready = 1;
        step("under.rlast_m0");
        clear_r();
        step("under.sticky0");
        step("under.sticky1");

        // Asynchronous reset while a request waits in SEND.
        m1_arvalid = 1; s_arready = 0; rand_req(1);
        step("midreset.accept");
        m1_arvalid = 0;
        #1 ARESETn = 0;
        #1;
        check("midreset.s_arvalid", 64'(s_arvalid), 64'(0));
        check("midreset.err", 64'(err), 64'(0));
        model_reset();
        @(posedge ACLK);
        #1 ARESETn = 1;
        s_arready = 1;
        step("midreset.after");

        // Randomized traffic; completions only target masters with work pending.
        for (int i = 0; i < 400; i++) begin
            bit sel;
            m0_arvalid = 1'($urandom); m1_arvalid = 1'($urandom);
            rand_req(0); rand_req(1);
            s_arready = ($urandom_range(3) != 0);
            sel = 1'($urandom);
            s_rid = {sel, 1'($urandom)};
            s_rvalid = (mdl_out[sel] > 0) && 1'($urandom);
            s_rlast = 1'($urandom);
            m0_rready = 1'($urandom); m1_rready = 1'($urandom);
            s_rdata = $urandom; s_rresp = 2'($urandom);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Two-master to one-slave arbiter for the AXI read path, placed in front of the read slave.
- Arbitrates the AR channels round-robin and registers the winning request toward the slave.
- Widens ARID with a master-select MSB to form the slave tag, and routes R beats back by RID MSB.
- Limits outstanding bursts per master so the slave's per-tag queues cannot overflow.

Parameters:
- BusWidth, 32, address/data width.
- IdBits, 1, per-master ID width; slave tag width = IdBits+1.
- MaxOutstanding, 4, max accepted-but-incomplete bursts per master.
- CntBits, 3, outstanding counter width; must hold MaxOutstanding.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- mN_arid  in  IdBits  master N AR ID (N = 0, 1; same for all mN_ lines below).
- mN_araddr  in  BusWidth  master N start address.
- mN_arlen/arsize/arburst/arlock/arcache/arprot  in  4/2/2/2/4/3  master N AR control.
- mN_arvalid  in  1  master N request valid.
- mN_arready  out  1  master N request accepted.
- s_arid  out  IdBits+1  {master, mN_arid}.
- s_araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  as master  registered payload.
- s_arvalid  out  1  request to slave valid.
- s_arready  in  1  slave accepts request.
- s_rid  in  IdBits+1  slave read tag.
- s_rdata  in  BusWidth  slave read data.
- s_rresp  in  2  slave read response.
- s_rlast  in  1  slave last beat.
- s_rvalid  in  1  slave beat valid.
- s_rready  out  1  selected master ready.
- mN_rid  out  IdBits  s_rid[IdBits-1:0].
- mN_rdata/rresp/rlast  out  BusWidth/2/1  broadcast from slave.
- mN_rvalid  out  1  s_rvalid & (s_rid[IdBits]==N).
- mN_rready  in  1  master N ready.
- err  out  1  sticky: RLAST completion received for a master with zero outstanding.

Behaviour:
- Reset: FSM=IDLE; round-robin pointer favours M0; both counters 0; s_arvalid=0; s_ar* payload=0; err=0; mN_arready=0.
- Eligibility: master N is eligible when mN_arvalid=1 and cntN<MaxOutstanding.
- IDLE state:
  - If exactly one master is eligible, it is granted.
  - If both are eligible, the pointer's master is granted.
  - mN_arready=1 combinationally in IDLE for the granted master only, so accept happens in the same cycle.
  - On that edge: capture the payload, set s_arid={N, mN_arid}, set s_arvalid=1, pointer := other master, cntN++, go to SEND.
  - If no master is eligible, stay in IDLE.
- SEND state:
  - Both mN_arready=0.
  - s_arvalid and payload are held stable until s_arready=1.
  - On the edge with s_arready=1: s_arvalid := 0, go to IDLE.
- AR latency: master accept to s_arvalid high is 1 cycle. Minimum spacing is 2 cycles per grant; no back-to-back grant from SEND.
- R routing:
  - Purely combinational, no storage.
  - s_rready = m[s_rid[IdBits]]_rready.
  - The non-selected master sees mN_rvalid=0.
- Completion: on s_rvalid & s_rready & s_rlast, decrement the counter of master s_rid[IdBits].
- Simultaneous increment and decrement on the same master leaves the counter unchanged.
- Decrement at 0: counter stays 0 and err := 1 (sticky until reset).
- Increment at MaxOutstanding cannot occur, because the master is ineligible.
- Reset mid-SEND: s_arvalid drops immediately (asynchronous); the in-flight request is discarded and counters clear.

Decomposition:
- Shared package axi_pkg:
  - AXI burst constants FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
  - AR control field widths; ArPayloadW = BusWidth+17.
  - Arbiter state encodings IDLE/SEND.
- Sub-module axi_outstanding_ctr: saturating up/down counter with limit compare and underflow flag; instantiated once per master.

Test Plan:
- M0 only: m0_arid=1, araddr=0x100, arlen=3, s_arready=1 -> m0_arready pulses 1 cycle; next cycle s_arvalid=1, s_arid=2'b01, s_araddr=0x100; cnt0=1.
- Both valid in the same cycle after reset -> M0 granted first (s_arid MSB=0), M1 granted 2 cycles later (s_arid=2'b1x); with both held valid, grants alternate M0, M1, M0.
- s_arready held 0 for 5 cycles in SEND -> s_arvalid and payload stable all 5 cycles; both mN_arready stay 0.
- M1 issues 4 bursts with no R completions -> 5th request is not accepted while M0 requests are still granted; one RLAST beat with s_rid=2'b10 -> M1 accepted next IDLE.
- R routing: s_rid=2'b11, s_rvalid=1, m1_rready=0 -> m1_rvalid=1, m0_rvalid=0, s_rready=0; raise m1_rready -> s_rready=1; with s_rlast=1, cnt1 decrements.
- Underflow/reset: RLAST for M0 with cnt0=0 -> err=1 and stays high; assert ARESETn=0 during SEND -> s_arvalid=0, err=0, counters 0 immediately.
